// File: rtl/ps2_kbd_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_ctrl_if
// Handshake between a PS/2 receiver FIFO and the scan-code controller.
//   kbd_data     : scan-code byte. It is valid the cycle after rd_en.
//   kbd_ready    : FIFO is non-empty.
//   kbd_overflow : FIFO overflow indication.
//   rd_en        : one-cycle pop request from the controller.
// The master modport is the controller side. The slave modport is the FIFO side.
// ---------------------------------------------------------------------------
interface ps2_kbd_ctrl_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       rd_en;

  modport master (
    input  kbd_data,
    input  kbd_ready,
    input  kbd_overflow,
    output rd_en
  );

  modport slave (
    output kbd_data,
    output kbd_ready,
    output kbd_overflow,
    input  rd_en
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_kbd_ctrl
// Pops scan-code bytes from a PS/2 receiver FIFO and decodes E0 (extended)
// and F0 (break) prefixes into key events. It tracks the held key,
// suppresses typematic repeats and counts distinct key presses.
// Ports:
//   clk, clrn  : clock. clrn is an asynchronous, active-low reset.
//   kbd        : FIFO handshake (data, ready, overflow, rd_en).
//   key_valid  : one-cycle pulse. The event outputs are updated this cycle.
//   key_code   : final (non-prefix) code of the last event.
//   key_ext    : the last event carried an E0 prefix.
//   key_brk    : the last event was a break (key release).
//   key_held   : a key is currently held down.
//   press_cnt  : count of distinct key presses. It wraps.
//   err        : sticky flag for a receiver overflow.
//   clr_err    : synchronous clear of err. An overflow in the same cycle wins.
// Parameter PREFIX_TIMEOUT: number of cycles a pending prefix survives.
// ---------------------------------------------------------------------------
module ps2_kbd_ctrl #(
  parameter logic [23:0] PREFIX_TIMEOUT = 24'd5000000
) (
  input  logic               clk,
  input  logic               clrn,
  ps2_kbd_ctrl_if.master     kbd,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_brk,
  output logic               key_held,
  output logic [7:0]         press_cnt,
  output logic               err,
  input  logic               clr_err
);

  typedef enum logic [1:0] {IDLE, POP, LATCH} state_t;

  state_t      state_q, state_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_ext_q, key_ext_d;
  logic        key_brk_q, key_brk_d;
  logic        held_q, held_d;
  logic [8:0]  held_key_q, held_key_d;   // {ext, code} of the held key
  logic [7:0]  press_cnt_q, press_cnt_d;
  logic        err_q, err_d;
  logic        pend_ext_q, pend_ext_d;
  logic        pend_brk_q, pend_brk_d;
  logic [23:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_brk_q   <= 1'b0;
      held_q      <= 1'b0;
      held_key_q  <= 9'h000;
      press_cnt_q <= 8'h00;
      err_q       <= 1'b0;
      pend_ext_q  <= 1'b0;
      pend_brk_q  <= 1'b0;
      timer_q     <= 24'h000000;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_brk_q   <= key_brk_d;
      held_q      <= held_d;
      held_key_q  <= held_key_d;
      press_cnt_q <= press_cnt_d;
      err_q       <= err_d;
      pend_ext_q  <= pend_ext_d;
      pend_brk_q  <= pend_brk_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_brk_d   = key_brk_q;
    held_d      = held_q;
    held_key_d  = held_key_q;
    press_cnt_d = press_cnt_q;
    err_d       = err_q;
    pend_ext_d  = pend_ext_q;
    pend_brk_d  = pend_brk_q;
    timer_d     = timer_q;

    // An overflow has priority over a clear in the same cycle.
    if (kbd.kbd_overflow) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end

    // The prefix timer runs only while a prefix is pending. If a byte is
    // decoded in the same cycle, the decode below overrides the timer.
    if (pend_ext_q || pend_brk_q) begin
      if (timer_q >= PREFIX_TIMEOUT - 24'd1) begin
        pend_ext_d = 1'b0;
        pend_brk_d = 1'b0;
        timer_d    = 24'h000000;
      end else begin
        timer_d = timer_q + 24'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (kbd.kbd_ready) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d = IDLE;
        if (kbd.kbd_data == 8'hE0) begin
          pend_ext_d = 1'b1;
          timer_d    = 24'h000000;
        end else if (kbd.kbd_data == 8'hF0) begin
          pend_brk_d = 1'b1;
          timer_d    = 24'h000000;
        end else begin
          pend_ext_d = 1'b0;
          pend_brk_d = 1'b0;
          timer_d    = 24'h000000;
          if (pend_brk_q) begin
            key_valid_d = 1'b1;
            key_code_d  = kbd.kbd_data;
            key_ext_d   = pend_ext_q;
            key_brk_d   = 1'b1;
            // Releasing a key other than the held one leaves the held key unchanged.
            if (held_q && (held_key_q == {pend_ext_q, kbd.kbd_data})) begin
              held_d = 1'b0;
            end
          end else if (!(held_q && (held_key_q == {pend_ext_q, kbd.kbd_data}))) begin
            // A make for the already-held key is a typematic repeat and is dropped.
            key_valid_d = 1'b1;
            key_code_d  = kbd.kbd_data;
            key_ext_d   = pend_ext_q;
            key_brk_d   = 1'b0;
            held_d      = 1'b1;
            held_key_d  = {pend_ext_q, kbd.kbd_data};
            press_cnt_d = press_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign kbd.rd_en = (state_q == POP);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_brk   = key_brk_q;
  assign key_held  = held_q;
  assign press_cnt = press_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_ctrl
// Directed testbench for ps2_kbd_ctrl. It uses a short prefix timeout.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_ctrl;
  localparam logic [23:0] TMO = 24'd20;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       clr_err = 1'b0;
  logic       key_valid, key_ext, key_brk, key_held, err;
  logic [7:0] key_code, press_cnt;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int rd_consec = 0;
  logic rd_prev = 1'b0;

  ps2_kbd_ctrl_if kif ();

  ps2_kbd_ctrl #(.PREFIX_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .kbd       (kif.master),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_brk   (key_brk),
    .key_held  (key_held),
    .press_cnt (press_cnt),
    .err       (err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // Monitor: counts event pulses and any back-to-back rd_en.
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_cnt++;
    if (kif.rd_en === 1'b1 && rd_prev === 1'b1) rd_consec++;
    rd_prev = kif.rd_en;
  end

  // Offer one byte. The task returns at the negedge of the IDLE cycle
  // that follows LATCH, with key_valid captured in ev.
  task automatic send_byte(input logic [7:0] b, output logic ev);
    int t;
    t = 0;
    kif.kbd_ready = 1'b1;
    while (kif.rd_en !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      vectors++; miscompares++;
      $display("FAIL rd_en_timeout: rd_en never rose, required 1 within 20 cycles");
    end
    kif.kbd_data  = b;
    kif.kbd_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ev = key_valid;
  endtask

  task automatic test_reset;
    clrn = 1'b1;
    #2 clrn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({kif.rd_en, key_valid, key_ext, key_brk, key_held, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 000000",
               {kif.rd_en, key_valid, key_ext, key_brk, key_held, err});
    end
    vectors++;
    if ({key_code, press_cnt} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_code_cnt: got %h, required 0000", {key_code, press_cnt});
    end
    clrn = 1'b1;
    #1;
    vectors++;
    if (kif.rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_rd: got %b, required 0", kif.rd_en);
    end
    @(negedge clk);
  endtask

  task automatic test_make_break;
    logic ev;
    send_byte(8'h1C, ev);
    vectors++;
    if ({ev, key_code, key_ext, key_brk, key_held, press_cnt} !== {1'b1, 8'h1C, 3'b001, 8'd1}) begin
      miscompares++;
      $display("FAIL make_1c: got ev=%b code=%h ext=%b brk=%b held=%b cnt=%0d, required 1 1c 0 0 1 1",
               ev, key_code, key_ext, key_brk, key_held, press_cnt);
    end
    send_byte(8'hF0, ev);
    vectors++;
    if (ev !== 1'b0) begin
      miscompares++;
      $display("FAIL prefix_f0_event: got %b, required 0", ev);
    end
    send_byte(8'h1C, ev);
    vectors++;
    if ({ev, key_code, key_ext, key_brk, key_held, press_cnt} !== {1'b1, 8'h1C, 3'b010, 8'd1}) begin
      miscompares++;
      $display("FAIL break_1c: got ev=%b code=%h ext=%b brk=%b held=%b cnt=%0d, required 1 1c 0 1 0 1",
               ev, key_code, key_ext, key_brk, key_held, press_cnt);
    end
  endtask

  task automatic test_ext;
    logic ev;
    send_byte(8'hE0, ev);
    vectors++;
    if (ev !== 1'b0) begin
      miscompares++;
      $display("FAIL prefix_e0_event: got %b, required 0", ev);
    end
    send_byte(8'h75, ev);
    vectors++;
    if ({ev, key_code, key_ext, key_brk, key_held, press_cnt} !== {1'b1, 8'h75, 3'b101, 8'd2}) begin
      miscompares++;
      $display("FAIL make_e075: got ev=%b code=%h ext=%b brk=%b held=%b cnt=%0d, required 1 75 1 0 1 2",
               ev, key_code, key_ext, key_brk, key_held, press_cnt);
    end
    send_byte(8'hE0, ev);
    send_byte(8'hF0, ev);
    send_byte(8'h75, ev);
    vectors++;
    if ({ev, key_code, key_ext, key_brk, key_held, press_cnt} !== {1'b1, 8'h75, 3'b110, 8'd2}) begin
      miscompares++;
      $display("FAIL break_e075: got ev=%b code=%h ext=%b brk=%b held=%b cnt=%0d, required 1 75 1 1 0 2",
               ev, key_code, key_ext, key_brk, key_held, press_cnt);
    end
  endtask

  task automatic test_typematic;
    logic ev;
    int p0;
    p0 = pulse_cnt;
    send_byte(8'h1C, ev);
    send_byte(8'h1C, ev);
    send_byte(8'h1C, ev);
    vectors++;
    if ({ev, key_code, key_brk, key_held} !== {1'b0, 8'h1C, 2'b01}) begin
      miscompares++;
      $display("FAIL typematic_hold: got ev=%b code=%h brk=%b held=%b, required 0 1c 0 1",
               ev, key_code, key_brk, key_held);
    end
    send_byte(8'hF0, ev);
    send_byte(8'h1C, ev);
    vectors++;
    if ((pulse_cnt - p0) != 2 || press_cnt !== 8'd3 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL typematic_count: got pulses=%0d cnt=%0d held=%b, required 2 3 0",
               pulse_cnt - p0, press_cnt, key_held);
    end
  endtask

  task automatic test_nonmatch_break;
    logic ev;
    send_byte(8'h1C, ev);
    send_byte(8'hF0, ev);
    send_byte(8'h32, ev);
    vectors++;
    if ({ev, key_code, key_brk, key_held, press_cnt} !== {1'b1, 8'h32, 2'b11, 8'd4}) begin
      miscompares++;
      $display("FAIL nonmatch_break: got ev=%b code=%h brk=%b held=%b cnt=%0d, required 1 32 1 1 4",
               ev, key_code, key_brk, key_held, press_cnt);
    end
    send_byte(8'hF0, ev);
    send_byte(8'h1C, ev);
    vectors++;
    if (key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL match_break_held: got %b, required 0", key_held);
    end
  endtask

  task automatic test_timeout;
    logic ev;
    send_byte(8'hF0, ev);
    repeat (int'(TMO) + 2) @(negedge clk);
    send_byte(8'h1C, ev);
    vectors++;
    if ({ev, key_code, key_ext, key_brk, press_cnt} !== {1'b1, 8'h1C, 2'b00, 8'd5}) begin
      miscompares++;
      $display("FAIL prefix_timeout: got ev=%b code=%h ext=%b brk=%b cnt=%0d, required 1 1c 0 0 5",
               ev, key_code, key_ext, key_brk, press_cnt);
    end
    send_byte(8'hE0, ev);
    send_byte(8'hE0, ev);
    send_byte(8'h14, ev);
    vectors++;
    if ({ev, key_code, key_ext, key_brk, key_held, press_cnt} !== {1'b1, 8'h14, 3'b101, 8'd6}) begin
      miscompares++;
      $display("FAIL repeat_prefix: got ev=%b code=%h ext=%b brk=%b held=%b cnt=%0d, required 1 14 1 0 1 6",
               ev, key_code, key_ext, key_brk, key_held, press_cnt);
    end
  endtask

  task automatic test_overflow;
    kif.kbd_overflow = 1'b1;
    @(negedge clk);
    kif.kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b, required 0", err);
    end
    kif.kbd_overflow = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    kif.kbd_overflow = 1'b0;
    clr_err = 1'b0;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set_wins: got %b, required 1", err);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_wrap;
    logic ev;
    // 8'h14 with ext is held. Plain 15/16 alternate, so every make is a new press.
    for (int i = 0; i < 256; i++) begin
      send_byte((i % 2 == 0) ? 8'h15 : 8'h16, ev);
    end
    vectors++;
    if (press_cnt !== 8'd6 || key_code !== 8'h16) begin
      miscompares++;
      $display("FAIL press_wrap: got cnt=%0d code=%h, required 6 16", press_cnt, key_code);
    end
  endtask

  task automatic test_back_to_back;
    vectors++;
    if (rd_consec != 0) begin
      miscompares++;
      $display("FAIL rd_en_spacing: got %0d consecutive rd_en cycles, required 0", rd_consec);
    end
  endtask

  task automatic test_reset_mid_latch;
    int p0;
    int t;
    t = 0;
    kif.kbd_ready = 1'b1;
    while (kif.rd_en !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    kif.kbd_data  = 8'h2A;
    kif.kbd_ready = 1'b0;
    @(negedge clk);           // DUT is now in LATCH
    p0 = pulse_cnt;
    clrn = 1'b0;
    #1;
    vectors++;
    if ({kif.rd_en, key_valid, key_ext, key_brk, key_held, err, key_code, press_cnt} !== 22'h0) begin
      miscompares++;
      $display("FAIL reset_mid_latch: got %h, required 0",
               {kif.rd_en, key_valid, key_ext, key_brk, key_held, err, key_code, press_cnt});
    end
    @(negedge clk);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (pulse_cnt != p0 || press_cnt !== 8'd0 || key_code !== 8'h00) begin
      miscompares++;
      $display("FAIL abandon_byte: got pulses=%0d cnt=%0d code=%h, required 0 0 00",
               pulse_cnt - p0, press_cnt, key_code);
    end
  endtask

  initial begin
    kif.kbd_data     = 8'h00;
    kif.kbd_ready    = 1'b0;
    kif.kbd_overflow = 1'b0;
    test_reset();
    test_make_break();
    test_ext();
    test_typematic();
    test_nonmatch_break();
    test_timeout();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid_latch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
